// File: rtl/mdu_sequencer_pkg.sv
// mdu_sequencer_pkg: MDU op encodings, latency defaults, sequencer state type and op classifier
package mdu_sequencer_pkg;

    localparam int MDU_OP_WIDTH = 4;

    localparam logic [MDU_OP_WIDTH-1:0] MDU_MUL    = 4'd0;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULH   = 4'd1;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHSU = 4'd2;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHU  = 4'd3;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_DIV    = 4'd4;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_DIVU   = 4'd5;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_REM    = 4'd6;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_REMU   = 4'd7;

    localparam int MDU_MUL_CYCLES = 4;
    localparam int MDU_DIV_CYCLES = 33;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } mdu_seq_state_t;

    // Anything that is not one of the four multiplies runs with divide latency,
    // so unknown encodings get the longest (safe) schedule.
    function automatic logic is_div_class(input logic [MDU_OP_WIDTH-1:0] op);
        return !(op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU});
    endfunction

endpackage

// File: rtl/mdu_iter_counter.sv
// mdu_iter_counter: loadable down-counter with clear, load, enable and zero flag
// Ports: clk, rst_n (async active-low), clr (highest priority), load + load_val,
//        en (decrement, saturates at 0), zero (count == 0).
module mdu_iter_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              cnt <= '0;
        else if (clr)            cnt <= '0;
        else if (load)           cnt <= load_val;
        else if (en && !zero)    cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multicycle start/step/last sequencer for the iterative RV32M multiply/divide unit
// Ports: req_valid_i/req_ready_o + mdu_op_i/rd_addr_i/divisor_zero_i (decode side),
//        mdu_start_o/mdu_op_o/mdu_step_o/mdu_last_o/div0_o (MDU side),
//        stall_o/busy_o (pipeline), wb_valid_o/wb_ready_i/wb_rd_addr_o (write-back),
//        flush_i aborts from any state. Build option: MDU_FAST_MUL_EN (single-cycle multiplies).
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int MUL_CYCLES = MDU_MUL_CYCLES,
    parameter int DIV_CYCLES = MDU_DIV_CYCLES,
    parameter int CNT_WIDTH  = $clog2(DIV_CYCLES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [MDU_OP_WIDTH-1:0] mdu_op_i,
    input  logic [4:0]              rd_addr_i,
    input  logic                    divisor_zero_i,
    input  logic                    flush_i,
    output logic                    mdu_start_o,
    output logic [MDU_OP_WIDTH-1:0] mdu_op_o,
    output logic                    mdu_step_o,
    output logic                    mdu_last_o,
    output logic                    div0_o,
    output logic                    stall_o,
    output logic                    busy_o,
    output logic                    wb_valid_o,
    input  logic                    wb_ready_i,
    output logic [4:0]              wb_rd_addr_o
);

    mdu_seq_state_t state, state_nxt;
    logic           accept, div_op, fast_mul, skip_exec, cnt_zero;
    logic [CNT_WIDTH-1:0] cnt_load;

    assign req_ready_o = (state == IDLE) & ~flush_i;
    assign accept      = req_valid_i & req_ready_o;
    assign div_op      = is_div_class(mdu_op_i);
`ifdef MDU_FAST_MUL_EN
    assign fast_mul    = ~div_op;
`else
    assign fast_mul    = 1'b0;
`endif
    // Div-by-zero and single-cycle multiplies bypass EXEC entirely.
    assign skip_exec   = (div_op & divisor_zero_i) | fast_mul;
    assign cnt_load    = div_op ? CNT_WIDTH'(DIV_CYCLES - 1) : CNT_WIDTH'(MUL_CYCLES - 1);

    mdu_iter_counter #(.W(CNT_WIDTH)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (flush_i),
        .load     (accept),
        .en       (state == EXEC),
        .load_val (cnt_load),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush_i)              state_nxt = IDLE;
        else if (state == IDLE)   state_nxt = accept ? (skip_exec ? DONE : EXEC) : IDLE;
        else if (state == EXEC)   state_nxt = cnt_zero ? DONE : EXEC;
        else if (state == DONE)   state_nxt = wb_ready_i ? IDLE : DONE;
        else                      state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdu_op_o     <= MDU_MUL;
            wb_rd_addr_o <= '0;
            div0_o       <= 1'b0;
        end else if (flush_i) begin
            div0_o       <= 1'b0;
        end else if (accept) begin
            mdu_op_o     <= mdu_op_i;
            wb_rd_addr_o <= rd_addr_i;
            div0_o       <= div_op & divisor_zero_i;
        end else if (state == DONE && wb_ready_i) begin
            div0_o       <= 1'b0;
        end
    end

    assign mdu_start_o = accept;
    assign mdu_step_o  = (state == EXEC);
    assign mdu_last_o  = ((state == EXEC) & cnt_zero) | (accept & fast_mul);
    assign wb_valid_o  = (state == DONE);
    assign busy_o      = (state != IDLE);
    assign stall_o     = accept | (state == EXEC) | ((state == DONE) & ~wb_ready_i);

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: scoreboard bench for mdu_sequencer timing, handshakes, flush and reset
module tb_mdu_sequencer;
    import mdu_sequencer_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    req_valid = 1'b0;
    logic                    req_ready;
    logic [MDU_OP_WIDTH-1:0] mdu_op = '0;
    logic [4:0]              rd_addr = '0;
    logic                    dz = 1'b0;
    logic                    flush = 1'b0;
    logic                    mdu_start, mdu_step, mdu_last, div0, stall, busy, wb_valid;
    logic [MDU_OP_WIDTH-1:0] mdu_op_q;
    logic                    wb_ready = 1'b0;
    logic [4:0]              wb_rd;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [4:0] rd;
        logic       div0;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mdu_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .mdu_op_i       (mdu_op),
        .rd_addr_i      (rd_addr),
        .divisor_zero_i (dz),
        .flush_i        (flush),
        .mdu_start_o    (mdu_start),
        .mdu_op_o       (mdu_op_q),
        .mdu_step_o     (mdu_step),
        .mdu_last_o     (mdu_last),
        .div0_o         (div0),
        .stall_o        (stall),
        .busy_o         (busy),
        .wb_valid_o     (wb_valid),
        .wb_ready_i     (wb_ready),
        .wb_rd_addr_o   (wb_rd)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic tb_is_div(input logic [MDU_OP_WIDTH-1:0] op);
        return op > 4'd3;
    endfunction

    function automatic logic tb_fast(input logic [MDU_OP_WIDTH-1:0] op);
`ifdef MDU_FAST_MUL_EN
        return !tb_is_div(op);
`else
        return op > 4'd15;
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total++; if (busy !== 1'b0 || wb_valid !== 1'b0 || div0 !== 1'b0) begin
            $display("FAIL reset_state: busy=%b wb_valid=%b div0=%b want 0/0/0", busy, wb_valid, div0);
        end else passed++;
        total++; if (mdu_op_q !== MDU_MUL || wb_rd !== 5'd0) begin
            $display("FAIL reset_regs: op=%0d rd=%0d want 0/0", mdu_op_q, wb_rd);
        end else passed++;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        // start a divide and kill it with reset mid-EXEC
        req_valid = 1'b1; mdu_op = MDU_DIV; rd_addr = 5'd12; dz = 1'b0;
        next_cycle();
        req_valid = 1'b0;
        repeat (5) next_cycle();
        total++; if (mdu_step !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL reset_pre_exec: step=%b busy=%b want 1/1", mdu_step, busy);
        end else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || mdu_step !== 1'b0 || mdu_last !== 1'b0 || mdu_start !== 1'b0 || wb_valid !== 1'b0) begin
            $display("FAIL reset_mid_exec: busy=%b step=%b last=%b start=%b wbv=%b want all 0",
                     busy, mdu_step, mdu_last, mdu_start, wb_valid);
        end else passed++;
        total++; if (wb_rd !== 5'd0) begin
            $display("FAIL reset_mid_rd: rd=%0d want 0", wb_rd);
        end else passed++;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        total++; if (req_ready !== 1'b1 || stall !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset_release: ready=%b stall=%b busy=%b want 1/0/0", req_ready, stall, busy);
        end else passed++;
        next_cycle();
    endtask

    task automatic run_op(input string name, input logic [MDU_OP_WIDTH-1:0] op, input logic [4:0] rd,
                          input logic z, input int hold);
        int n, exp_steps, exp_last, exp_wb, steps, starts, last_c, wb_c;
        logic isdiv, fast, done;
        exp_t e;
        isdiv = tb_is_div(op);
        fast  = tb_fast(op);
        n     = isdiv ? 33 : 4;
        if ((isdiv && z) || fast) begin
            exp_steps = 0; exp_wb = 1; exp_last = fast ? 0 : -1;
        end else begin
            exp_steps = n; exp_wb = n + 1; exp_last = n;
        end
        steps = 0; starts = 0; last_c = -1; wb_c = -1; done = 1'b0;
        req_valid = 1'b1; mdu_op = op; rd_addr = rd; dz = z; wb_ready = (hold == 0) ? 1'b0 : 1'b0;
        sb.push_back('{rd, isdiv && z});
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                total++; if (mdu_start !== 1'b1 || stall !== 1'b1) begin
                    $display("FAIL %s accept: start=%b stall=%b want 1/1", name, mdu_start, stall);
                end else passed++;
            end
            if (mdu_start) starts++;
            if (mdu_step) steps++;
            if (mdu_last && last_c < 0) last_c = c;
            if (wb_valid) begin
                if (wb_c < 0) wb_c = c;
                total++; if (stall !== !wb_ready || wb_rd !== sb[0].rd || div0 !== sb[0].div0) begin
                    $display("FAIL %s done_hold c=%0d: stall=%b rd=%0d div0=%b want %b/%0d/%b",
                             name, c, stall, wb_rd, div0, !wb_ready, sb[0].rd, sb[0].div0);
                end else passed++;
                if (wb_ready) begin
                    e = sb.pop_front();
                    total++; if (wb_rd !== e.rd || div0 !== e.div0) begin
                        $display("FAIL %s wb_data: rd=%0d div0=%b want %0d/%b", name, wb_rd, div0, e.rd, e.div0);
                    end else passed++;
                    done = 1'b1;
                end
            end
            next_cycle();
            req_valid = 1'b0;
            wb_ready  = (wb_c >= 0) && (c + 1 - wb_c >= hold);
        end
        wb_ready = 1'b0;
        total++; if (!done) begin
            $display("FAIL %s timeout: no wb handshake within 100 cycles", name);
        end else passed++;
        total++; if (steps !== exp_steps || starts !== 1) begin
            $display("FAIL %s steps: steps=%0d starts=%0d want %0d/1", name, steps, starts, exp_steps);
        end else passed++;
        total++; if (last_c !== exp_last || wb_c !== exp_wb) begin
            $display("FAIL %s timing: last=%0d wb=%0d want %0d/%0d", name, last_c, wb_c, exp_last, exp_wb);
        end else passed++;
        @(negedge clk);
        total++; if (busy !== 1'b0 || req_ready !== 1'b1 || div0 !== 1'b0) begin
            $display("FAIL %s back_idle: busy=%b ready=%b div0=%b want 0/1/0", name, busy, req_ready, div0);
        end else passed++;
        next_cycle();
    endtask

    task automatic test_mul();
        run_op("mul", MDU_MUL, 5'd5, 1'b0, 3);
        run_op("mulhu", MDU_MULHU, 5'd21, 1'b0, 0);
    endtask

    task automatic test_div();
        run_op("div", MDU_DIV, 5'd7, 1'b0, 1);
        run_op("bad_op", 4'hF, 5'd30, 1'b0, 0);
        run_op("mul_dz", MDU_MULH, 5'd2, 1'b1, 0);
    endtask

    task automatic test_div0();
        run_op("divu_dz", MDU_DIVU, 5'd9, 1'b1, 0);
        run_op("rem_dz", MDU_REM, 5'd17, 1'b1, 2);
    endtask

    task automatic test_flush();
        int wb_seen;
        wb_seen = 0;
        req_valid = 1'b1; mdu_op = MDU_DIV; rd_addr = 5'd4; dz = 1'b0;
        next_cycle();
        req_valid = 1'b0;
        for (int c = 1; c < 10; c++) next_cycle();
        flush = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL flush_c10: ready=%b busy=%b want 0/1", req_ready, busy);
        end else passed++;
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0 || mdu_step !== 1'b0 || stall !== 1'b0) begin
            $display("FAIL flush_c11: busy=%b step=%b stall=%b want 0/0/0", busy, mdu_step, stall);
        end else passed++;
        wb_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            next_cycle();
            @(negedge clk);
            if (wb_valid || busy) wb_seen++;
        end
        wb_ready = 1'b0;
        total++; if (wb_seen !== 0) begin
            $display("FAIL flush_no_wb: wb_valid/busy cycles=%0d want 0", wb_seen);
        end else passed++;
        next_cycle();
        // flush with a request in IDLE must not accept it
        flush = 1'b1; req_valid = 1'b1; mdu_op = MDU_MUL; rd_addr = 5'd1;
        @(negedge clk);
        total++; if (req_ready !== 1'b0 || mdu_start !== 1'b0 || stall !== 1'b0) begin
            $display("FAIL flush_idle: ready=%b start=%b stall=%b want 0/0/0", req_ready, mdu_start, stall);
        end else passed++;
        next_cycle();
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin
            $display("FAIL flush_idle_next: busy=%b want 0", busy);
        end else passed++;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        int k, st[$], hs[$];
        exp_t e;
        k = tb_fast(MDU_MUL) ? 1 : 5;
        req_valid = 1'b1; mdu_op = MDU_MUL; rd_addr = 5'd3; dz = 1'b0; wb_ready = 1'b1;
        sb.push_back('{5'd3, 1'b0});
        sb.push_back('{5'd9, 1'b1});
        for (int c = 0; c < 60 && hs.size() < 2; c++) begin
            @(negedge clk);
            if (mdu_start) st.push_back(c);
            if (wb_valid && wb_ready) begin
                hs.push_back(c);
                e = sb.pop_front();
                total++; if (wb_rd !== e.rd || div0 !== e.div0) begin
                    $display("FAIL b2b_wb%0d: rd=%0d div0=%b want %0d/%b", hs.size(), wb_rd, div0, e.rd, e.div0);
                end else passed++;
            end
            next_cycle();
            mdu_op = MDU_DIVU; rd_addr = 5'd9; dz = 1'b1;
            if (st.size() >= 2) req_valid = 1'b0;
        end
        req_valid = 1'b0; wb_ready = 1'b0;
        total++; if (st.size() != 2 || hs.size() != 2) begin
            $display("FAIL b2b_counts: starts=%0d handshakes=%0d want 2/2", st.size(), hs.size());
        end else begin
            if (st[0] !== 0 || hs[0] !== k || st[1] !== k + 1 || hs[1] !== k + 2) begin
                $display("FAIL b2b_timing: st0=%0d hs0=%0d st1=%0d hs1=%0d want 0/%0d/%0d/%0d",
                         st[0], hs[0], st[1], hs[1], k, k + 1, k + 2);
            end else passed++;
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div0();
        test_flush();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multicycle sequencer for the iterative multiply/divide unit (MDU) of the RV32IM core.
- Accepts one MDU operation from decode via a valid/ready handshake and drives the MDU start, step and last strobes.
- Holds the pipeline stalled while the operation runs.
- Presents the finished result to write-back via a second valid/ready handshake. Supports flush abort and a divide-by-zero fast path.

Parameters:
- MUL_CYCLES, 4, EXEC cycles for MUL/MULH/MULHSU/MULHU; legal range 1..DIV_CYCLES.
- DIV_CYCLES, 33, EXEC cycles for DIV/DIVU/REM/REMU; minimum 1.
- CNT_WIDTH, $clog2(DIV_CYCLES+1), iteration counter width; derived, never overridden.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  decode presents an MDU op (controller mdu_op flag)
- req_ready_o  out  1  sequencer can accept
- mdu_op_i  in  MDU_OP_WIDTH  MDU operation encoding
- rd_addr_i  in  5  destination register
- divisor_zero_i  in  1  operand B == 0, sampled at accept
- flush_i  in  1  pipeline flush
- mdu_start_o  out  1  load operands into MDU, one-cycle pulse
- mdu_op_o  out  MDU_OP_WIDTH  latched operation
- mdu_step_o  out  1  MDU iteration enable
- mdu_last_o  out  1  final iteration strobe
- div0_o  out  1  result must take the RISC-V div-by-zero value
- stall_o  out  1  freeze fetch/decode
- busy_o  out  1  state != IDLE
- wb_valid_o  out  1  result ready for write-back
- wb_ready_i  in  1  write-back accepts
- wb_rd_addr_o  out  5  latched destination register

Behaviour:
- States: IDLE, EXEC, DONE. All registers clear asynchronously on rst_n low, including mid-operation.
- Reset values: state=IDLE, counter=0, mdu_op_o=MDU_MUL, wb_rd_addr_o=0, div0_o=0. In IDLE with no request, all strobes and wb_valid_o are 0.
- req_ready_o = (state==IDLE) & ~flush_i.
- accept = req_valid_i & req_ready_o. In the accept cycle:
  - mdu_start_o=1 (combinational).
  - mdu_op_i and rd_addr_i are latched.
  - The counter loads N-1, where N is MUL_CYCLES or DIV_CYCLES by op class.
- IDLE->EXEC on accept.
- IDLE->DONE instead on accept of DIV/DIVU/REM/REMU with divisor_zero_i=1. This sets div0_o=1, and no step/last is issued.
- EXEC:
  - mdu_step_o=1 every cycle; the counter decrements.
  - mdu_last_o=1 when counter==0.
  - EXEC->DONE after the last cycle.
  - Accept at cycle 0 gives EXEC in cycles 1..N and wb_valid_o at cycle N+1.
- DONE:
  - wb_valid_o=1, stable with wb_rd_addr_o and div0_o until wb_ready_i.
  - On the handshake, DONE->IDLE and div0_o clears.
  - No new request is accepted in the handshake cycle; the earliest re-accept is the following IDLE cycle.
- stall_o = accept | (state==EXEC) | (state==DONE & ~wb_ready_i).
- busy_o = (state != IDLE).
- Flush:
  - flush_i in any state returns to IDLE on the next edge.
  - The counter clears, and wb_valid_o and div0_o drop in the next cycle.
  - flush_i has priority over wb handshake and over accept.
- mdu_op encodings not in the M set are treated as the DIV class (safe max latency).

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU use a single-cycle multiplier.
  - The accept cycle asserts mdu_start_o and mdu_last_o together.
  - The state goes IDLE->DONE directly, so wb_valid_o appears at cycle 1 and mdu_step_o is never asserted for multiplies.
  - MUL_CYCLES is ignored.
- Undefined: multiplies iterate MUL_CYCLES as above. Divides are identical in both builds.

Decomposition:
- riscv_defines already holds MDU_OP_WIDTH and the MDU_* encodings; add MDU_DIV_CYCLES and MDU_MUL_CYCLES defaults there.
- ctrl_typedefs gains mdu_seq_state_t (IDLE/EXEC/DONE) and an is_div_class function.
- One natural sub-module: mdu_iter_counter, a loadable down-counter with load/enable/zero flag, CNT_WIDTH wide.

Test Plan:
All scenarios use defaults (MUL_CYCLES=4, DIV_CYCLES=33) and accept at cycle 0.
- Reset: assert rst_n=0 mid-EXEC -> state, strobes and wb_valid_o are 0 immediately. After release: req_ready_o=1, stall_o=0.
- MUL, rd=5:
  - mdu_start_o at cycle 0, mdu_step_o cycles 1-4, mdu_last_o cycle 4.
  - wb_valid_o at cycle 5 with wb_rd_addr_o=5.
  - Hold wb_ready_i=0 for 3 cycles -> outputs stable and stall_o=1 until the handshake.
- DIV, divisor nonzero, rd=7 -> 33 step cycles, mdu_last_o at cycle 33, wb_valid_o at cycle 34, div0_o=0.
- DIVU with divisor_zero_i=1 -> wb_valid_o and div0_o at cycle 1, no mdu_step_o. REM with divisor zero behaves the same.
- Flush:
  - flush_i at cycle 10 of a DIV -> IDLE at cycle 11, no wb_valid_o ever.
  - flush_i with req_valid_i in IDLE -> not accepted, req_ready_o=0.
- Back-to-back: req_valid_i held high across a wb handshake at cycle k -> next op accepted at k+1 with mdu_start_o=1. With MDU_FAST_MUL_EN defined, MUL gives wb_valid_o at cycle 1.
